// File: rtl/sm_mant_addsub_pipe.sv
// sm_mant_addsub_pipe: two-stage sign-magnitude mantissa add/sub with valid/ready; define SM_ADDSUB_LZC_EN to register a leading-zero count
module sm_mant_addsub_pipe #(
    parameter int MW = 24,
    localparam int LZW = $clog2(MW + 2)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic           sa_i,
    input  logic           sb_i,
    input  logic [MW-1:0]  ma_i,
    input  logic [MW-1:0]  mb_i,
    input  logic           op_sub_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [MW:0]    result_o,
    output logic           s_o,
    output logic           zero_o,
    output logic [LZW-1:0] lzc_o
);
    logic          v1_q, v2_q, adv1, adv2;
    logic          eff_sub_q, sgn_q, eff_sub_d, sgn_d, sbe, a_ge_b;
    logic [MW-1:0] big_q, small_q, big_d, small_d;
    logic [MW:0]   sum_d, res_q;
    logic          s_q, zero_q;

    assign adv2        = !v2_q || out_ready_i;
    assign adv1        = !v1_q || adv2;
    assign in_ready_o  = adv1;
    assign out_valid_o = v2_q;
    assign result_o    = res_q;
    assign s_o         = s_q;
    assign zero_o      = zero_q;

    // Compare/swap: larger magnitude goes to big; exact cancellation is forced to +0
    always_comb begin
        sbe       = sb_i ^ op_sub_i;
        eff_sub_d = sa_i ^ sbe;
        a_ge_b    = ma_i >= mb_i;
        big_d     = a_ge_b ? ma_i : mb_i;
        small_d   = a_ge_b ? mb_i : ma_i;
        sgn_d     = (eff_sub_d && ma_i == mb_i) ? 1'b0 : (a_ge_b ? sa_i : sbe);
    end

    // Stage 1 register, loads only when the pipeline can advance
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1_q      <= 1'b0;
            eff_sub_q <= 1'b0;
            sgn_q     <= 1'b0;
            big_q     <= '0;
            small_q   <= '0;
        end else if (adv1) begin
            v1_q      <= in_valid_i;
            eff_sub_q <= eff_sub_d;
            sgn_q     <= sgn_d;
            big_q     <= big_d;
            small_q   <= small_d;
        end
    end

    assign sum_d = eff_sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};

    // Stage 2 register holding the visible result while downstream stalls
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v2_q   <= 1'b0;
            res_q  <= '0;
            s_q    <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv2) begin
            v2_q   <= v1_q;
            res_q  <= sum_d;
            s_q    <= sgn_q;
            zero_q <= sum_d == '0;
        end
    end

`ifdef SM_ADDSUB_LZC_EN
    logic [LZW-1:0] lzc_q;

    function automatic logic [LZW-1:0] clz(input logic [MW:0] x);
        logic [LZW-1:0] n;
        n = LZW'(MW + 1);
        for (int i = 0; i <= MW; i++) if (x[i]) n = LZW'(MW - i);
        return n;
    endfunction

    // Leading-zero count registered alongside the result so it shares its latency
    always_ff @(posedge clk_i) begin
        if (!rst_ni) lzc_q <= '0;
        else if (adv2) lzc_q <= clz(sum_d);
    end

    assign lzc_o = lzc_q;
`else
    assign lzc_o = '0;
`endif
endmodule

// File: tb/tb_sm_mant_addsub_pipe.sv
// tb_sm_mant_addsub_pipe: directed table, backpressure, random and reset-mid-stream checks against a signed-arithmetic model
module tb_sm_mant_addsub_pipe;
    localparam int MW = 24;
    localparam int LZW = $clog2(MW + 2);
`ifdef SM_ADDSUB_LZC_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic           sa = 1'b0, sb = 1'b0, op_sub = 1'b0;
    logic [MW-1:0]  ma = '0, mb = '0;
    logic           in_ready, out_valid, s, zero;
    logic [MW:0]    result;
    logic [LZW-1:0] lzc;

    always #5 clk = ~clk;

    sm_mant_addsub_pipe #(.MW(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sa_i(sa), .sb_i(sb), .ma_i(ma), .mb_i(mb), .op_sub_i(op_sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .s_o(s), .zero_o(zero), .lzc_o(lzc)
    );

    typedef struct {
        logic [MW:0]    res;
        logic           s;
        logic           z;
        logic [LZW-1:0] lzc;
    } exp_t;

    typedef struct {
        logic          sa, sb, op;
        logic [MW-1:0] ma, mb;
        logic [MW:0]   res;
        logic          s, z;
        int            lz;
    } vec_t;

    exp_t        q[$];
    int          checks = 0, failures = 0;
    bit          mon_on = 1'b0, held_v = 1'b0;
    logic [MW:0] held_res;
    logic        held_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sa_, sb_, op_, input logic [MW-1:0] ma_, mb_);
        exp_t   e;
        longint a, b, sum;
        int     lz;
        logic   sbe_;
        sbe_  = sb_ ^ op_;
        a     = sa_ ? -longint'(ma_) : longint'(ma_);
        b     = sbe_ ? -longint'(mb_) : longint'(mb_);
        sum   = a + b;
        e.res = (MW+1)'(sum < 0 ? -sum : sum);
        e.s   = sum < 0 ? 1'b1 : sum > 0 ? 1'b0 : (sa_ == sbe_ ? sa_ : 1'b0);
        e.z   = sum == 0;
        lz    = MW + 1;
        for (int i = 0; i <= MW; i++) if (e.res[i]) lz = MW - i;
        e.lzc = LZ_ON ? LZW'(lz) : '0;
        return e;
    endfunction

    task automatic rnd_op();
        sa     = 1'($urandom);
        sb     = 1'($urandom);
        op_sub = 1'($urandom);
        ma     = MW'($urandom);
        mb     = ($urandom_range(0, 3) == 0) ? ma : MW'($urandom);
        if ($urandom_range(0, 15) == 0) ma = '0;
    endtask

    // Scoreboard: every accepted operand must come out once, in order, and hold steady while stalled
    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                q.delete();
                held_v = 1'b0;
            end else begin
                chk("in_ready", in_ready, (q.size() < 2) || out_ready);
                if (held_v) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_result", result, held_res);
                    chk("stall_sign", s, held_s);
                end
                held_v = 1'b0;
                if (out_valid) begin
                    if (q.size() == 0) chk("stale_out_valid", out_valid, 0);
                    else begin
                        chk("sb_result", result, q[0].res);
                        chk("sb_sign", s, q[0].s);
                        chk("sb_zero", zero, q[0].z);
                        chk("sb_lzc", lzc, q[0].lzc);
                        if (out_ready) void'(q.pop_front());
                        else begin
                            held_v   = 1'b1;
                            held_res = result;
                            held_s   = s;
                        end
                    end
                end
                if (in_valid && in_ready) q.push_back(model(sa, sb, op_sub, ma, mb));
            end
        end
    end

    initial begin
        vec_t vt[8];
        int   issued;
        bit   need_new, full;
        vt[0] = '{0, 0, 0, 24'h800000, 24'h800000, 25'h1000000, 0, 0, 0};
        vt[1] = '{0, 1, 0, 24'h400000, 24'h600000, 25'h0200000, 1, 0, 3};
        vt[2] = '{1, 1, 1, 24'hABCDEF, 24'hABCDEF, 25'h0000000, 0, 1, 25};
        vt[3] = '{1, 1, 0, 24'h000000, 24'h000000, 25'h0000000, 1, 1, 25};
        vt[4] = '{0, 0, 1, 24'hFFFFFF, 24'h000001, 25'h0FFFFFE, 0, 0, 1};
        vt[5] = '{1, 0, 0, 24'h000001, 24'h000003, 25'h0000002, 0, 0, 23};
        vt[6] = '{0, 0, 1, 24'h000000, 24'h000005, 25'h0000005, 1, 0, 22};
        vt[7] = '{1, 1, 0, 24'hFFFFFF, 24'hFFFFFF, 25'h1FFFFFE, 1, 0, 0};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        rnd_op();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_sign", s, 0);
        chk("rst_zero", zero, 0);
        chk("rst_lzc", lzc, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        mon_on   = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            {sa, sb, op_sub, ma, mb} = {vt[i].sa, vt[i].sb, vt[i].op, vt[i].ma, vt[i].mb};
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early_valid", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vt[i].res);
            chk($sformatf("vec%0d_sign", i), s, vt[i].s);
            chk($sformatf("vec%0d_zero", i), zero, vt[i].z);
            chk($sformatf("vec%0d_lzc", i), lzc, LZ_ON ? vt[i].lz : 0);
        end

        issued   = 0;
        need_new = 1'b1;
        for (int c = 0; c < 40 && (issued < 6 || q.size() > 0); c++) begin
            @(posedge clk);
            #1;
            out_ready = !(c >= 3 && c < 7);
            if (issued < 6) begin
                if (need_new) rnd_op();
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            @(negedge clk);
            if (c == 5) chk("bp_full_in_ready", in_ready, 0);
            need_new = in_valid && in_ready;
            if (need_new) issued++;
        end
        chk("bp_issued", issued, 6);
        chk("bp_drained", q.size(), 0);

        need_new = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            out_ready = $urandom_range(0, 9) < 7;
            if (need_new) begin
                rnd_op();
                in_valid = 1'(($urandom_range(0, 3)) != 0);
            end
            @(negedge clk);
            need_new = !in_valid || in_ready;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rand_drained", q.size(), 0);

        full = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10 && !full; c++) begin
            @(negedge clk);
            full = out_valid && !in_ready;
            if (!full) begin
                @(posedge clk);
                #1;
                rnd_op();
            end
        end
        chk("rstmid_full", full, 1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rstmid_no_output", out_valid, 0);
        end
        chk("rstmid_queue", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
